// File: rtl/decoder_scan_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the decoder_scan block.
//   dec_state_t : operating state of the decoder (OFF / DIRECT / SCAN)
//   MODE_DIRECT : value of the mode input that selects direct decode
//   MODE_SCAN   : value of the mode input that selects autonomous scanning
// ---------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
// Purely combinational N-to-2^N one-hot decoder.
// Ports:
//   In  [N-1:0]      : binary select
//   Out [2^N-1:0]    : one-hot output, bit In is set
// ---------------------------------------------------------------------------
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]        In,
  output logic [(1 << N)-1:0] Out
);

  localparam int W = 1 << N;

  logic [W-1:0] one_w;

  assign one_w = W'(1);
  assign Out   = one_w << In;

endmodule

// File: rtl/decoder_scan.sv
// ---------------------------------------------------------------------------
// decoder_scan
// Registered N-to-2^N one-hot decoder with enable and two modes: direct
// decode of In, or autonomous scanning where the index steps through every
// output, holding each one for DWELL clock cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides all other inputs
//   E    : enable; low forces the outputs inactive
//   mode : 0 = direct decode, 1 = scan
//   In   : select in direct mode, start index when scan is entered
//   Out  : registered one-hot output, all-zero when disabled
//   idx  : registered current index
//   wrap : one-cycle pulse when the scan index rolls from 2^N-1 to 0
// ---------------------------------------------------------------------------
module decoder_scan #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                E,
  input  logic                mode,
  input  logic [N-1:0]        In,
  output logic [(1 << N)-1:0] Out,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  import decoder_pkg::*;

  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

  dec_state_t    state;
  dec_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [N-1:0]  idx_nxt;
  logic          wrap_nxt;
  logic [W-1:0]  dec_out;

  // State register: reset parks the block in OFF so the first enabled cycle
  // afterwards is treated as a fresh entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state depends only on the sampled enable and mode, every cycle.
  always_comb begin
    state_nxt = OFF;
    if (E) begin
      state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  // Next index, dwell count and wrap pulse. Entering SCAN from any other
  // state reloads the index from In with a fresh dwell, so a start at 0
  // never looks like a wrap. Only a genuine increment past the top index
  // raises wrap.
  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    case (state_nxt)
      DIRECT: begin
        idx_nxt = In;
      end
      SCAN: begin
        if (state != SCAN) begin
          idx_nxt = In;
        end else if (cnt == CNT_LAST) begin
          idx_nxt  = idx + 1'b1;
          wrap_nxt = (idx == IDX_LAST);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        idx_nxt = idx;
      end
    endcase
  end

  // The decoder sits on the next-index path so Out is registered together
  // with idx and always agrees with it.
  onehot_dec #(.N(N)) u_onehot_dec (
    .In  (idx_nxt),
    .Out (dec_out)
  );

  // Datapath registers; Out is blanked whenever the next state is OFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
      Out  <= '0;
    end else begin
      idx  <= idx_nxt;
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
      Out  <= (state_nxt == OFF) ? '0 : dec_out;
    end
  end

endmodule
